charli_drive: RTL and testbench
===============================

# charli_drive

Scan driver for the 56-LED Charlieplexed array on the Basys2 expansion board. It takes a 56-bit LED image from a pattern generator and multiplexes the image onto 8 tri-stateable pins, one anode pin per scan phase. It sits between the pattern source and the top-level IOBUFs (`pin_out` / `pin_oe`). Dead-time blanking between phases prevents ghosting.

## Interface
- `SCAN_DIV`, default 6250: clock cycles per scan phase (50 MHz / 6250 = 8 kHz phase rate, 1 kHz frame rate); legal range 4..65535.
- `BLANK_CYC`, default 50: cycles at the start of each phase with all pins hi-Z; legal range 1..SCAN_DIV-2.
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: scan enable; low means display off and scan held at start of frame.
- `data` in 56: LED image; bit i = 1 lights LED i.
- `pin_out` in/out n/a, out 8: output value per pin, valid where `pin_oe` = 1.
- `pin_oe` out 8: per-pin output enable; 0 = hi-Z.
- `frame_start` out 1: one-cycle pulse when a new image is latched.

## Operation
- Internal state:
  - `phase` counts 0..7.
  - `cnt` counts 0..SCAN_DIV-1.
  - `shadow[55:0]` holds the image being displayed.
  - The phase FSM has two states, BLANK (cnt < BLANK_CYC) and DRIVE (cnt >= BLANK_CYC).
- Counting while `en` = 1:
  - `cnt` increments each cycle.
  - At cnt = SCAN_DIV-1, `cnt` goes to 0 and `phase` goes to phase+1.
  - After phase 7, `phase` wraps to 0.
- Latch event: every transition into (phase 0, cnt 0) loads `shadow` <= `data`. This happens on the 7 -> 0 wrap and on every cycle `en` is low. `data` is never sampled mid-frame, so there is no tearing.
- While `en` = 0, `phase` and `cnt` are forced to 0 and `shadow` reloads every cycle.
- BLANK: `pin_oe` = 0, `pin_out` = 0.
- DRIVE in phase k:
  - Anode pin k: oe = 1, out = 1.
  - For each pin j ≠ k, define m = j when j < k, else m = j-1. The LED index is k*7+m.
  - If `shadow[k*7+m]` = 1, pin j is driven with oe = 1, out = 0. Otherwise pin j is hi-Z (oe = 0, out = 0).
- The anode is driven in DRIVE even when the phase is all-dark.
- At no time are two pins driven high together.

## Timing
- All outputs are registered. `pin_out`, `pin_oe` and `frame_start` reflect the (phase, cnt, shadow, en) state of the previous cycle, a fixed 1-cycle latency.
- Reset (`rst` = 0, any time, asynchronous):
  - `pin_out` = 0, `pin_oe` = 0, `frame_start` = 0.
  - `phase` = 0, `cnt` = 0, `shadow` = 0.
- The first frame after reset release is dark. The first latch of `data` occurs at the first 7 -> 0 wrap, unless `en` was low first.
- `frame_start` is 1 in the cycle after any latch event, so it stays high continuously while `en` = 0.
- `en` falling: `pin_oe` = 0 from the next cycle, regardless of FSM state.
- `en` rising: the first `en` = 1 cycle is (0,0). Scan restarts at phase 0, BLANK, using the image latched in the last `en` = 0 cycle.
- Reset asserted mid-DRIVE: pins go hi-Z immediately (asynchronous). No partial phase resumes.
- Frame length is exactly 8*SCAN_DIV cycles. Each phase has BLANK_CYC blank cycles and SCAN_DIV-BLANK_CYC drive cycles.
- Each LED's duty cycle is (SCAN_DIV-BLANK_CYC)/(8*SCAN_DIV).
- Counter widths: `cnt` is 16 bits, `phase` is 3 bits, with no overflow across the legal parameter range.

## Test plan
Unless stated otherwise, the bench uses SCAN_DIV = 8 and BLANK_CYC = 2.
- Reset and first frame:
  - Stimulus: hold `rst` = 0, release with `en` = 1 and `data` = all-ones.
  - Required: all outputs 0 during reset.
  - Required: frame 0 shows anode pulses only (oe = one-hot, out = one-hot), with cathodes hi-Z.
  - Required: `frame_start` pulses at cycle 65.
  - Required: frame 1 drives all 7 cathodes low in every DRIVE window.
- Single-LED mapping:
  - Stimulus: for each i in 0..55, `data` = 1<<i.
  - Required: exactly one phase k = i/7 shows `pin_oe` = (1<<k) | (1<<j) with `pin_out` = 1<<k, where j = m if m < k else m+1 and m = i%7.
  - Required: every other phase has `pin_oe` = 1<<phase only.
- Blanking:
  - Required: across all phases, `pin_oe` = 0 for exactly 2 consecutive cycles at each phase boundary.
  - Required: `pin_out` never has more than one bit set.
- Tear-free latch:
  - Stimulus: change `data` from 0x00..01 to 0x80..00 at phase 3.
  - Required: the display keeps bit 0 through the end of the frame; bit 55 appears (phase 7, pin 6 low) only in the next frame.
- Enable:
  - Stimulus: drop `en` mid-phase 5 for 3 cycles.
  - Required: `pin_oe` = 0 from the next cycle.
  - Required: `frame_start` stays high for 3 cycles.
  - Required: on resume, phase 0 BLANK with the latest `data`.
- Asynchronous reset mid-DRIVE:
  - Stimulus: assert `rst` between clock edges during phase 2 DRIVE.
  - Required: `pin_oe` goes to 0 without waiting for a clock edge.
  - Required: after release, the frame restarts dark.

Source files
------------

// File: rtl/charli_drive_if.sv
// -----------------------------------------------------------------------------
// charli_drive_if
//
// Bundle between the pattern source and the Charlieplex scan driver.
//
// Signals
//   en          : scan enable (source -> driver). Low blanks the display and
//                 parks the scan at the start of a frame.
//   data[55:0]  : LED image (source -> driver). Bit i = 1 lights LED i.
//   pin_out[7:0]: per-pin output value (driver -> IOBUFs), meaningful where
//                 pin_oe = 1.
//   pin_oe[7:0] : per-pin output enable (driver -> IOBUFs), 0 = hi-Z.
//   frame_start : one-cycle pulse (driver -> source) in the cycle after an
//                 image was latched.
//   dbg_drive   : phase FSM state (0 = BLANK, 1 = DRIVE), observation only.
//
// Handshake: there is no valid/ready pair. The source keeps `data` stable at
// all times it may be sampled; the driver samples it only on a latch edge (the
// 7 -> 0 phase wrap, or any edge with en = 0) and acknowledges each sample by
// raising frame_start for the following cycle. A source that wants to swap
// images tear-free updates `data` in response to frame_start.
//
// Modports
//   master : pattern-source side (drives en/data).
//   slave  : scan-driver side (drives pins, frame_start, dbg_drive).
// -----------------------------------------------------------------------------
interface charli_drive_if;
  logic        en;
  logic [55:0] data;
  logic [7:0]  pin_out;
  logic [7:0]  pin_oe;
  logic        frame_start;
  logic        dbg_drive;

  modport master (
    output en,
    output data,
    input  pin_out,
    input  pin_oe,
    input  frame_start,
    input  dbg_drive
  );

  modport slave (
    input  en,
    input  data,
    output pin_out,
    output pin_oe,
    output frame_start,
    output dbg_drive
  );
endinterface

// File: rtl/charli_drive.sv
// -----------------------------------------------------------------------------
// charli_drive
//
// Scan driver for a 56-LED Charlieplexed array on 8 tri-stateable pins.
// One pin is the anode per scan phase (driven high); the other seven pins are
// cathodes, driven low only for the LEDs that are lit in that phase, hi-Z
// otherwise. Each phase starts with BLANK_CYC cycles of all-hi-Z dead time so
// the previous phase's charge cannot ghost into the next one.
//
// The displayed image lives in a shadow register that is reloaded only when
// the scan enters (phase 0, cnt 0), so a frame is never torn by a mid-frame
// change of `data`.
//
// Parameters
//   SCAN_DIV  : clock cycles per scan phase, 4..65535.
//   BLANK_CYC : dead-time cycles at the start of each phase, 1..SCAN_DIV-2.
//
// Ports
//   clk : system clock.
//   rst : asynchronous, active-low reset.
//   bus : charli_drive_if.slave -- en/data in; pin_out/pin_oe/frame_start and
//         the dbg_drive state tap out.
//
// Timing: all outputs are registered and reflect the (phase, cnt, shadow, en)
// state of the previous cycle. Frame length is exactly 8*SCAN_DIV cycles.
// -----------------------------------------------------------------------------
module charli_drive #(
  parameter int unsigned SCAN_DIV  = 6250,
  parameter int unsigned BLANK_CYC = 50
) (
  input  logic          clk,
  input  logic          rst,
  charli_drive_if.slave bus
);

  // Elaboration-time guard on the legal parameter range.
  if (SCAN_DIV < 4 || SCAN_DIV > 65535) begin : g_bad_scan_div
    $error("charli_drive: SCAN_DIV out of range 4..65535");
  end
  if (BLANK_CYC < 1 || BLANK_CYC > SCAN_DIV - 2) begin : g_bad_blank_cyc
    $error("charli_drive: BLANK_CYC out of range 1..SCAN_DIV-2");
  end

  localparam logic [15:0] CNT_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLANK_END = 16'(BLANK_CYC);
  localparam logic [2:0]  PHASE_LAST = 3'd7;

  // Phase FSM: BLANK while cnt < BLANK_CYC, DRIVE for the rest of the phase.
  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_e;

  state_e      state_q, state_d;

  // Scan position and displayed image.
  logic [2:0]  phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic [55:0] shadow_q, shadow_d;
  logic        latch;

  // Registered outputs.
  logic [7:0]  pin_out_q, pin_out_d;
  logic [7:0]  pin_oe_q, pin_oe_d;
  logic        frame_start_q, frame_start_d;

  // Pin pattern derivation for the current phase.
  logic [7:0]  anode;
  logic [5:0]  row_base;
  logic [6:0]  row;
  logic [7:0]  row8;
  logic [7:0]  low_mask;
  logic [7:0]  cathodes;

  // ---------------------------------------------------------------------------
  // Scan counters and image latch.
  // Disabled: position is forced to (0,0) and the shadow follows `data` every
  // cycle, so re-enabling starts a fresh frame with the newest image.
  // Enabled: cnt runs 0..SCAN_DIV-1, phase advances at the end of each phase
  // and the 7 -> 0 wrap is the only point where the image is taken.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    shadow_d = shadow_q;
    latch    = 1'b0;

    if (!bus.en) begin
      cnt_d   = '0;
      phase_d = '0;
      latch   = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = phase_q + 3'd1;
      if (phase_q == PHASE_LAST) begin
        latch = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    if (latch) begin
      shadow_d = bus.data;
    end
  end

  // ---------------------------------------------------------------------------
  // Phase FSM next state. The state tracks which window the *next* cnt value
  // lands in, so state_q always agrees with cnt_q.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = S_BLANK;
    if (cnt_d >= BLANK_END) begin
      state_d = S_DRIVE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pin pattern for phase k.
  // The seven LEDs of phase k sit at shadow[7k +: 7]. Row bit m belongs to pin
  // m when m < k and to pin m+1 otherwise, i.e. the row is split at bit k and
  // the upper part is shifted up by one to skip over the anode pin. This also
  // guarantees the anode bit of `cathodes` is 0.
  // ---------------------------------------------------------------------------
  assign anode    = 8'd1 << phase_q;
  assign row_base = {phase_q, 3'b000} - {3'b000, phase_q};
  assign row      = shadow_q[row_base +: 7];
  assign row8     = {1'b0, row};
  assign low_mask = anode - 8'd1;
  assign cathodes = (row8 & low_mask) | ((row8 & ~low_mask) << 1);

  always_comb begin
    pin_oe_d      = '0;
    pin_out_d     = '0;
    frame_start_d = latch;

    // Only the anode is ever driven high, so at most one pin is high at once.
    // Dropping en blanks on the very next cycle regardless of FSM state.
    if (bus.en && state_q == S_DRIVE) begin
      pin_oe_d  = anode | cathodes;
      pin_out_d = anode;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers. Reset is asynchronous so the pins go hi-Z the
  // instant rst falls, even in the middle of a DRIVE window.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q       <= '0;
      cnt_q         <= '0;
      shadow_q      <= '0;
      pin_out_q     <= '0;
      pin_oe_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      pin_out_q     <= pin_out_d;
      pin_oe_q      <= pin_oe_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.pin_out     = pin_out_q;
  assign bus.pin_oe      = pin_oe_q;
  assign bus.frame_start = frame_start_q;
  assign bus.dbg_drive   = (state_q == S_DRIVE);

endmodule

// File: tb/tb_charli_drive.sv
// -----------------------------------------------------------------------------
// tb_charli_drive
//
// Bench for charli_drive with SCAN_DIV = 8, BLANK_CYC = 2 (64-cycle frame).
// A frame-level model (position in frame + latched image) predicts the pins
// from the LED-index rules; a compare process checks every cycle; directed
// sequences add literal expectations at chosen points.
//
// Cycle bookkeeping: inputs change just after a falling edge; after n rising
// edges since an event the outputs describe frame position n-1.
// -----------------------------------------------------------------------------
module tb_charli_drive;

  localparam int SCAN   = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = 8 * SCAN;

  // ---------------------------------------------------------------- clock/reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  charli_drive_if bus ();

  charli_drive #(
    .SCAN_DIV  (SCAN),
    .BLANK_CYC (BLANK)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  // ---------------------------------------------------------------- counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // The model knows only "how far into the frame we are" and "which image is
  // on display"; pin values come from walking the 56 LED indices.
  int          m_pos = 0;
  logic [55:0] m_img = '0;
  logic [7:0]  e_oe  = '0;
  logic [7:0]  e_out = '0;
  logic        e_fs  = 1'b0;

  function automatic logic [7:0] model_oe(input int pos, input logic [55:0] img, input logic en_s);
    int ph;
    int c;
    logic [7:0] r;
    r  = '0;
    ph = pos / SCAN;
    c  = pos % SCAN;
    if (en_s && c >= BLANK) begin
      r[ph] = 1'b1;
      for (int i = 0; i < 56; i++) begin
        if ((i / 7) == ph && img[i]) begin
          int m;
          m = i % 7;
          r[(m < ph) ? m : m + 1] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] model_out(input int pos, input logic en_s);
    logic [7:0] r;
    r = '0;
    if (en_s && (pos % SCAN) >= BLANK) r[pos / SCAN] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos <= 0;
      m_img <= '0;
      e_oe  <= '0;
      e_out <= '0;
      e_fs  <= 1'b0;
    end else begin
      e_oe  <= model_oe(m_pos, m_img, bus.en);
      e_out <= model_out(m_pos, bus.en);
      e_fs  <= !bus.en || (m_pos == FRAME - 1);
      if (!bus.en || (m_pos == FRAME - 1)) m_img <= bus.data;
      m_pos <= bus.en ? (m_pos + 1) % FRAME : 0;
    end
  end

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    check("pin_oe",      bus.pin_oe,      e_oe);
    check("pin_out",     bus.pin_out,     e_out);
    check("frame_start", bus.frame_start, e_fs);
    check("pin_out_single_high", ($countones(bus.pin_out) <= 1), 1'b1);
    check("fsm_state",   bus.dbg_drive,   ((m_pos % SCAN) >= BLANK));
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Literal single-LED expectations: LED index, frame position, oe, out.
  int         lit_i  [3] = '{0, 20, 55};
  int         lit_pos[3] = '{4, 20, 60};
  logic [7:0] lit_oe [3] = '{8'h03, 8'h84, 8'hC0};
  logic [7:0] lit_out[3] = '{8'h01, 8'h04, 8'h80};

  // ---------------------------------------------------------------- stimulus
  initial begin
    int nz;
    int fs_cnt;

    bus.en   = 1'b1;
    bus.data = '1;

    // Reset held: everything low.
    tick(3);
    check("rst_pin_oe",      bus.pin_oe,      8'h00);
    check("rst_pin_out",     bus.pin_out,     8'h00);
    check("rst_frame_start", bus.frame_start, 1'b0);
    rst_n = 1'b1;

    // Frame 0 is dark: phase 3 drive shows the anode only.
    tick(29);
    check("f0_ph3_oe",  bus.pin_oe,  8'h08);
    check("f0_ph3_out", bus.pin_out, 8'h08);
    tick(34);
    check("fs_before_65", bus.frame_start, 1'b0);
    tick(1);
    check("fs_cycle_65",  bus.frame_start, 1'b1);
    tick(1);
    check("fs_after_65",  bus.frame_start, 1'b0);

    // Frame 1 with all-ones: every cathode low in phase 2 drive.
    tick(20);
    check("f1_ph2_oe",  bus.pin_oe,  8'hFF);
    check("f1_ph2_out", bus.pin_out, 8'h04);

    // Blanking: 8 phases x 2 dead cycles in a 64-cycle window.
    nz = 0;
    for (int t = 0; t < FRAME; t++) begin
      tick(1);
      if (bus.pin_oe == 8'h00) nz++;
    end
    check("blank_cycles_per_frame", nz, 16);

    // Single-LED mapping for every index.
    for (int i = 0; i < 56; i++) begin
      int n2;
      bus.en   = 1'b0;
      bus.data = 56'd1 << i;
      tick(1);
      bus.en = 1'b1;
      n2 = 0;
      for (int t = 1; t <= FRAME; t++) begin
        tick(1);
        if ($countones(bus.pin_oe) == 2) n2++;
        for (int c = 0; c < 3; c++) begin
          if (lit_i[c] == i && lit_pos[c] == t - 1) begin
            check("single_led_oe",  bus.pin_oe,  lit_oe[c]);
            check("single_led_out", bus.pin_out, lit_out[c]);
          end
        end
      end
      check("single_led_drive_cycles", n2, SCAN - BLANK);
    end

    // Tear-free latch: bit 0 on display, data switches to bit 55 in phase 3.
    bus.en   = 1'b0;
    bus.data = 56'd1;
    tick(1);
    bus.en = 1'b1;
    tick(25);
    bus.data = 56'd1 << 55;
    tick(36);
    check("tear_same_frame_ph7_oe",  bus.pin_oe,  8'h80);
    check("tear_same_frame_ph7_out", bus.pin_out, 8'h80);
    tick(3);
    check("tear_wrap_frame_start", bus.frame_start, 1'b1);
    tick(5);
    check("tear_next_ph0_oe", bus.pin_oe, 8'h01);
    tick(56);
    check("tear_next_ph7_oe",  bus.pin_oe,  8'hC0);
    check("tear_next_ph7_out", bus.pin_out, 8'h80);

    // Enable dropped mid-phase 5 drive for 3 cycles.
    tick(48);
    check("en_ph5_drive_oe", bus.pin_oe, 8'h20);
    bus.en   = 1'b0;
    bus.data = 56'd1 << 40;
    fs_cnt   = 0;
    tick(1);
    check("en_off_oe", bus.pin_oe, 8'h00);
    fs_cnt += int'(bus.frame_start);
    bus.data = 56'd1 << 10;
    tick(1);
    fs_cnt += int'(bus.frame_start);
    tick(1);
    fs_cnt += int'(bus.frame_start);
    bus.en = 1'b1;
    tick(1);
    fs_cnt += int'(bus.frame_start);
    check("en_resume_blank", bus.pin_oe, 8'h00);
    check("en_fs_high_cycles", fs_cnt, 3);
    tick(12);
    check("en_resume_ph1_oe",  bus.pin_oe,  8'h12);
    check("en_resume_ph1_out", bus.pin_out, 8'h02);

    // Asynchronous reset in phase 2 drive.
    tick(8);
    check("arst_pre_oe", bus.pin_oe, 8'h04);
    #2 rst_n = 1'b0;
    #1;
    check("arst_oe_immediate",  bus.pin_oe,  8'h00);
    check("arst_out_immediate", bus.pin_out, 8'h00);
    @(negedge clk);
    bus.data = '1;
    rst_n    = 1'b1;
    tick(13);
    check("arst_dark_ph1_oe",  bus.pin_oe,  8'h02);
    check("arst_dark_ph1_out", bus.pin_out, 8'h02);
    tick(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
